// File: rtl/instr_loader.sv
// Program loader: assembles big-endian 32-bit words from a byte stream into program
// memory writes, then clocks the pipeline continuously or one debug step at a time.
module instr_loader #(
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  parameter int          PM_DEPTH  = 32,
  localparam int         AW        = $clog2(PM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  input  logic          i_mode_step,
  input  logic          i_step_req,
  input  logic          i_halt_in,
  output logic [31:0]   o_instruction_in,
  output logic [AW-1:0] o_instr_addr,
  output logic          o_flag_i,
  output logic          o_flag_step,
  output logic          o_load_done,
  output logic          o_err_overflow,
  output logic [31:0]   o_cycle_count,
  output logic [1:0]    o_state
);

  // Debug encoding on o_state: 0 LOAD, 1 RUN, 2 STEP, 3 DONE.
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(PM_DEPTH - 1);

  state_t        r_state;
  logic [1:0]    r_byte_idx;
  logic [7:0]    r_bytes [3];
  logic [AW-1:0] r_addr;
  logic [31:0]   r_instr;
  logic [AW-1:0] r_instr_addr;
  logic          r_flag_i;
  logic          r_flag_step;
  logic          r_load_done;
  logic          r_err;
  logic [31:0]   r_cycle_count;
  logic          r_step_hist;

  logic [31:0]   w_word;
  logic          w_step_edge;

  // The fourth byte completes the word straight from the input port.
  assign w_word      = {r_bytes[0], r_bytes[1], r_bytes[2], i_rx_data};
  assign w_step_edge = i_step_req & ~r_step_hist;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= S_LOAD;
      r_byte_idx    <= 2'd0;
      r_addr        <= '0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
      r_flag_i      <= 1'b0;
      r_flag_step   <= 1'b0;
      r_load_done   <= 1'b0;
      r_err         <= 1'b0;
      r_cycle_count <= '0;
      r_step_hist   <= 1'b0;
    end else begin
      r_flag_i    <= 1'b0;
      r_step_hist <= i_step_req;
      if (r_flag_step && (r_cycle_count != 32'hFFFFFFFF))
        r_cycle_count <= r_cycle_count + 32'd1;

      case (r_state)
        S_LOAD: begin
          if (i_rx_valid) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx != 2'd3) begin
              r_bytes[r_byte_idx] <= i_rx_data;
            end else begin
              r_instr      <= w_word;
              r_instr_addr <= r_addr;
              r_flag_i     <= 1'b1;
              r_addr       <= r_addr + AW'(1);
              if (w_word == HALT_WORD) begin
                r_load_done <= 1'b1;
                if (i_mode_step) begin
                  r_state <= S_STEP;
                end else begin
                  // Continuous mode clocks the pipeline from the first cycle in RUN.
                  r_state     <= S_RUN;
                  r_flag_step <= 1'b1;
                end
              end else if (r_addr == LAST_ADDR) begin
                r_load_done <= 1'b1;
                r_err       <= 1'b1;
                r_state     <= S_DONE;
              end
            end
          end
        end
        S_RUN: begin
          if (i_halt_in) begin
            r_flag_step <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_flag_step <= 1'b1;
          end
        end
        S_STEP: begin
          // Halt takes priority over a coincident step request.
          if (i_halt_in) begin
            r_flag_step <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_flag_step <= w_step_edge;
          end
        end
        S_DONE: begin
          r_flag_step <= 1'b0;
        end
        default: begin
          r_state     <= S_LOAD;
          r_flag_step <= 1'b0;
        end
      endcase
    end
  end

  assign o_instruction_in = r_instr;
  assign o_instr_addr     = r_instr_addr;
  assign o_flag_i         = r_flag_i;
  assign o_flag_step      = r_flag_step;
  assign o_load_done      = r_load_done;
  assign o_err_overflow   = r_err;
  assign o_cycle_count    = r_cycle_count;
  assign o_state          = r_state;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a cycle model of the loader rules checked every
// cycle, plus literal write lists and pulse counts for each scenario.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mode_step = 1'b0;
  logic        step_req = 1'b0;
  logic        halt_in = 1'b0;
  logic [31:0] o_instruction_in;
  logic [4:0]  o_instr_addr;
  logic        o_flag_i;
  logic        o_flag_step;
  logic        o_load_done;
  logic        o_err_overflow;
  logic [31:0] o_cycle_count;
  logic [1:0]  o_state;

  instr_loader dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_valid       (rx_valid),
    .i_mode_step      (mode_step),
    .i_step_req       (step_req),
    .i_halt_in        (halt_in),
    .o_instruction_in (o_instruction_in),
    .o_instr_addr     (o_instr_addr),
    .o_flag_i         (o_flag_i),
    .o_flag_step      (o_flag_step),
    .o_load_done      (o_load_done),
    .o_err_overflow   (o_err_overflow),
    .o_cycle_count    (o_cycle_count),
    .o_state          (o_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;
  int s_pulses = 0;
  int s_rises = 0;
  logic prev_fs = 1'b0;

  logic [36:0] exp_q[$];
  logic [36:0] wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 loading, 1 free-running, 2 single-step, 3 finished.
  int          m_phase;
  int          m_nb;
  logic [31:0] m_acc;
  int          m_addr;
  logic [31:0] m_word;
  logic [4:0]  m_eaddr;
  logic        m_fi, m_fs, m_ld, m_err, m_prev;
  logic [31:0] m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_nb = 0; m_acc = 0; m_addr = 0; m_word = 0; m_eaddr = 0;
      m_fi = 0; m_fs = 0; m_ld = 0; m_err = 0; m_prev = 0; m_cnt = 0;
    end else begin
      if (m_fs && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
      m_fi = 0;
      case (m_phase)
        0: if (rx_valid) begin
          m_acc = {m_acc[23:0], rx_data};
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0;
            m_word = m_acc;
            m_eaddr = m_addr[4:0];
            m_fi = 1;
            m_addr = (m_addr + 1) % 32;
            if (m_acc == 32'hFFFFFFFF) begin
              m_ld = 1;
              m_phase = mode_step ? 2 : 1;
              m_fs = !mode_step;
            end else if (m_eaddr == 5'd31) begin
              m_ld = 1; m_err = 1; m_phase = 3;
            end
          end
        end
        1: begin
          if (halt_in) begin m_fs = 0; m_phase = 3; end
          else m_fs = 1;
        end
        2: begin
          if (halt_in) begin m_fs = 0; m_phase = 3; end
          else m_fs = step_req && !m_prev;
        end
        default: m_fs = 0;
      endcase
      m_prev = step_req;
    end
  end

  // scoreboard compare process
  always @(negedge clk) begin
    if (checking) begin
      chk("flag_i", 64'(o_flag_i), 64'(m_fi));
      chk("instruction", 64'(o_instruction_in), 64'(m_word));
      chk("instr_addr", 64'(o_instr_addr), 64'(m_eaddr));
      chk("flag_step", 64'(o_flag_step), 64'(m_fs));
      chk("load_done", 64'(o_load_done), 64'(m_ld));
      chk("err_overflow", 64'(o_err_overflow), 64'(m_err));
      chk("cycle_count", 64'(o_cycle_count), 64'(m_cnt));
      if (o_flag_i === 1'b1) wlog.push_back({o_instr_addr, o_instruction_in});
    end
  end

  // driver tasks
  task automatic tick_acc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_flag_step === 1'b1) begin
        s_pulses++;
        if (!prev_fs) s_rises++;
      end
      prev_fs = o_flag_step;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; step_req = 1'b0; halt_in = 1'b0;
    tick_acc(1);
    rst_n = 1'b1;
    s_pulses = 0; s_rises = 0; prev_fs = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick_acc(1);
    rx_valid = 1'b0;
    tick_acc(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic check_writes(input string name);
    chk({name, "_nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      chk({name, "_write"}, 64'(wlog[i]), 64'(exp_q[i]));
    wlog.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    tick_acc(2);
    do_reset();
    checking = 1'b1;
    chk("reset_state", 64'(o_state), 64'd0);
    chk("reset_count", 64'(o_cycle_count), 64'd0);

    // Continuous load and run
    mode_step = 1'b0;
    send_word(32'h20080005);
    send_word(32'hFFFFFFFF);
    exp_q.push_back({5'd0, 32'h20080005});
    exp_q.push_back({5'd1, 32'hFFFFFFFF});
    check_writes("run_load");
    s_pulses = 0;
    tick_acc(10);
    chk("run_steps", 64'(s_pulses), 64'd10);
    chk("run_load_done", 64'(o_load_done), 64'd1);

    // Step mode: three short requests and one long hold
    do_reset();
    mode_step = 1'b1;
    send_word(32'h20080005);
    send_word(32'hFFFFFFFF);
    mode_step = 1'b0;
    exp_q.push_back({5'd0, 32'h20080005});
    exp_q.push_back({5'd1, 32'hFFFFFFFF});
    check_writes("step_load");
    tick_acc(3);
    chk("step_idle", 64'(s_pulses), 64'd0);
    repeat (3) begin
      step_req = 1'b1; tick_acc(2);
      step_req = 1'b0; tick_acc(2);
    end
    step_req = 1'b1; tick_acc(10);
    step_req = 1'b0; tick_acc(3);
    chk("step_pulses", 64'(s_pulses), 64'd4);
    chk("step_rises", 64'(s_rises), 64'd4);
    chk("step_count", 64'(o_cycle_count), 64'd4);
    chk("step_state", 64'(o_state), 64'd2);

    // Overflow: 32 words with no halt
    do_reset();
    for (int i = 0; i < 32; i++) begin
      send_word(32'h0A000000 + 32'(i));
      exp_q.push_back({5'(i), 32'h0A000000 + 32'(i)});
    end
    send_word(32'hFFFFFFFF);
    tick_acc(4);
    check_writes("ovf");
    chk("ovf_err", 64'(o_err_overflow), 64'd1);
    chk("ovf_done", 64'(o_load_done), 64'd1);
    chk("ovf_steps", 64'(s_pulses), 64'd0);
    chk("ovf_state", 64'(o_state), 64'd3);

    // Run, halt after 17 stepped cycles, then ignore everything
    do_reset();
    send_word(32'h12345678);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    rx_data = 8'hFF; rx_valid = 1'b1;
    budget = 0;
    while (s_pulses < 17 && budget < 200) begin
      tick_acc(1);
      rx_valid = 1'b0;
      budget++;
    end
    chk("halt_reached", 64'(s_pulses), 64'd17);
    halt_in = 1'b1;
    tick_acc(1);
    halt_in = 1'b0;
    chk("halt_flag_step", 64'(o_flag_step), 64'd0);
    step_req = 1'b1; tick_acc(2); step_req = 1'b0;
    send_word(32'h00000001);
    tick_acc(3);
    chk("halt_pulses", 64'(s_pulses), 64'd17);
    chk("halt_count", 64'(o_cycle_count), 64'd17);
    chk("halt_state", 64'(o_state), 64'd3);
    exp_q.push_back({5'd0, 32'h12345678});
    exp_q.push_back({5'd1, 32'hFFFFFFFF});
    check_writes("halt");

    // Reset mid-word with a coincident byte, then a clean word
    do_reset();
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0; rx_data = 8'h77; rx_valid = 1'b1;
    tick_acc(1);
    rst_n = 1'b1; rx_valid = 1'b0;
    tick_acc(1);
    send_word(32'h00000001);
    exp_q.push_back({5'd0, 32'h00000001});
    check_writes("midreset");

    // Reset while the write strobe is high
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rx_data = 8'h44; rx_valid = 1'b1;
    tick_acc(1);
    chk("strobe_high", 64'(o_flag_i), 64'd1);
    rx_valid = 1'b0; rst_n = 1'b0;
    tick_acc(1);
    rst_n = 1'b1;
    chk("strobe_cleared", 64'(o_flag_i), 64'd0);
    chk("strobe_addr", 64'(o_instr_addr), 64'd0);
    exp_q.push_back({5'd1, 32'h11223344});
    check_writes("strobe");

    // Step mode, halt coincident with a step edge
    do_reset();
    mode_step = 1'b1;
    send_word(32'hFFFFFFFF);
    mode_step = 1'b0;
    tick_acc(3);
    step_req = 1'b1; halt_in = 1'b1;
    tick_acc(1);
    halt_in = 1'b0;
    tick_acc(4);
    step_req = 1'b0; tick_acc(2);
    step_req = 1'b1; tick_acc(2);
    step_req = 1'b0; tick_acc(1);
    chk("halt_edge_pulses", 64'(s_pulses), 64'd0);
    chk("halt_edge_state", 64'(o_state), 64'd3);
    chk("halt_edge_count", 64'(o_cycle_count), 64'd0);
    exp_q.push_back({5'd0, 32'hFFFFFFFF});
    check_writes("halt_edge");

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker word.
REQ-002 Parameter PM_DEPTH, default 32, number of program-memory words; address width is 5 bits.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-low reset; RESET=0 at a CLK rising edge resets the block.
REQ-005 RX_DATA  in  8  byte from the serial receiver.
REQ-006 RX_VALID  in  1  one-cycle strobe; RX_DATA is valid this cycle.
REQ-007 MODE_STEP  in  1  sampled at end of load: 1 selects step mode, 0 selects continuous mode.
REQ-008 STEP_REQ  in  1  level from debug host; each 0->1 transition requests one pipeline step.
REQ-009 HALT_IN  in  1  pipeline has retired the halt instruction.
REQ-010 INSTRUCTION_IN  out  32  assembled instruction word to the processor top.
REQ-011 INSTR_ADDR  out  5  program-memory word address for INSTRUCTION_IN.
REQ-012 FLAG_I  out  1  one-cycle write strobe for INSTRUCTION_IN/INSTR_ADDR.
REQ-013 FLAG_STEP  out  1  pipeline clock-enable.
REQ-014 LOAD_DONE  out  1  program fully loaded; sticky until reset.
REQ-015 ERR_OVERFLOW  out  1  program exceeded PM_DEPTH without a halt word; sticky.
REQ-016 CYCLE_COUNT  out  32  number of cycles with FLAG_STEP=1 since reset.

Function
REQ-017 FSM states: LOAD, RUN, STEP, DONE; reset state LOAD.
REQ-018 LOAD: each RX_VALID byte shifts into a 2-bit-indexed byte assembler, big-endian (first byte -> [31:24], fourth -> [7:0]).
REQ-019 When the fourth byte is accepted at edge N, during cycle N+1: FLAG_I=1, INSTRUCTION_IN=word, INSTR_ADDR=current address; FLAG_I=0 in all other cycles.
REQ-020 Address increments by 1 after each write; byte index wraps 3->0 after each word.
REQ-021 HALT_WORD is itself written to memory; on that write, LOAD_DONE=1 next cycle and FSM goes to STEP if MODE_STEP=1, else RUN.
REQ-022 Non-halt word written at address 31: ERR_OVERFLOW=1 and LOAD_DONE=1, FSM goes to DONE; FLAG_STEP never asserts.
REQ-023 RX_VALID outside LOAD is ignored; INSTRUCTION_IN holds last written word.
REQ-024 RUN: FLAG_STEP=1 every cycle until HALT_IN=1, then FLAG_STEP=0 from next cycle and FSM goes to DONE.
REQ-025 STEP: registered edge detect on STEP_REQ; each rising edge yields FLAG_STEP=1 for exactly one cycle, one cycle after the edge is sampled.
REQ-026 STEP: STEP_REQ held high yields a single pulse; a new pulse requires STEP_REQ to return to 0.
REQ-027 HALT_IN and a STEP_REQ edge in the same cycle: HALT wins, no pulse, FSM goes to DONE.
REQ-028 DONE: FLAG_STEP=0, FLAG_I=0; stays until reset.
REQ-029 CYCLE_COUNT increments in each cycle FLAG_STEP=1; saturates at 32'hFFFFFFFF.

Reset
REQ-030 On reset: FSM=LOAD, byte index=0, address=0, INSTRUCTION_IN=0, INSTR_ADDR=0, FLAG_I=0, FLAG_STEP=0, LOAD_DONE=0, ERR_OVERFLOW=0, CYCLE_COUNT=0, edge-detect history=0.
REQ-031 Reset mid-word discards partial bytes; reset while FLAG_I=1 clears FLAG_I the next cycle.
REQ-032 RX_VALID coincident with active reset is ignored.

Verification
REQ-033 Bytes 20,08,00,05 then FF,FF,FF,FF, MODE_STEP=0 -> FLAG_I pulses with 32'h20080005 @addr0 and 32'hFFFFFFFF @addr1; LOAD_DONE=1; FLAG_STEP=1 continuously.
REQ-034 Same load, MODE_STEP=1, STEP_REQ toggled 0-1-0 three times, once held high 10 cycles -> exactly 4 one-cycle FLAG_STEP pulses, CYCLE_COUNT=4.
REQ-035 32 non-halt words -> 32 writes at addrs 0..31, ERR_OVERFLOW=1, LOAD_DONE=1, FLAG_STEP stays 0.
REQ-036 RUN mode, HALT_IN asserted after 17 FLAG_STEP cycles -> FLAG_STEP=0 next cycle, CYCLE_COUNT=17, FSM stays DONE despite further STEP_REQ/RX_VALID.
REQ-037 Two bytes sent, RESET=0 one cycle, then 4 bytes 00,00,00,01 -> single write 32'h00000001 @addr0, no stale bytes.
REQ-038 STEP mode, HALT_IN coincident with STEP_REQ rising edge -> no FLAG_STEP pulse, FSM=DONE.
